// File: rtl/reflect_pkg.sv
// Shared types and constants for the x-reflects-y stimulus generator and its checker bench.
package reflect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned LFSR_W = 8;

  // Right-shifting Fibonacci taps for x^8+x^6+x^5+x^4+1, output taken from bit 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'h1D;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/reflect_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous reload and step enable.
module reflect_lfsr8
  import reflect_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_VAL = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/reflect_stim_gen.sv
// Stimulus source for the x-reflects-y checker: LFSR-driven x, mirrored y with scheduled faults.
module reflect_stim_gen
  import reflect_pkg::*;
#(
  parameter int unsigned       NUM_CYCLES   = 64,
  parameter int unsigned       HOLD_CYCLES  = 2,
  parameter int unsigned       FAULT_PERIOD = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       fault_en,
  output logic       x,
  output logic       y,
  output logic       chk_en,
  output logic       busy,
  output logic       done,
  output logic [7:0] fault_cnt
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned PH_W   = 16;
  localparam int unsigned FCNT_W = 8;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(NUM_CYCLES - 1);
  localparam bit               FAULT_ON  = (FAULT_PERIOD != 0);
  localparam logic [PH_W-1:0]  PH_LOAD   = FAULT_ON ? PH_W'(FAULT_PERIOD - 1) : '0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                x_q, x_d, y_q, y_d;
  logic                chk_q, chk_d, busy_q, busy_d, done_q, done_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic                lfsr_load, lfsr_step;
  logic                emit, fault;
  logic [PH_W-1:0]     ph_cur;

  reflect_lfsr8 #(
    .RST_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (LFSR_SEED),
    .step (lfsr_step),
    .q    (lfsr_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      fcnt_q  <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      chk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      fcnt_q  <= fcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are computed for the cycle being entered, so x/y/chk_en register on the same edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ph_d      = ph_q;
    fcnt_d    = fcnt_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    emit      = 1'b0;
    fault     = 1'b0;
    ph_cur    = ph_q;
    x_d       = 1'b0;
    y_d       = 1'b0;
    chk_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HOLD;
          cnt_d     = HOLD_LOAD;
          lfsr_load = 1'b1;
          fcnt_d    = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = RUN_LOAD;
          ph_cur  = PH_LOAD;
          emit    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          emit  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Phase counter reaches zero on every FAULT_PERIOD-th run index, then reloads
    if (emit) begin
      fault     = FAULT_ON && (ph_cur == '0) && fault_en;
      ph_d      = (ph_cur == '0) ? PH_LOAD : ph_cur - PH_W'(1);
      lfsr_step = 1'b1;
      x_d       = lfsr_q[0];
      y_d       = lfsr_q[0] ^ fault;
      chk_d     = 1'b1;
      if (fault && (fcnt_q != '1)) begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end

    busy_d = (state_d == ST_HOLD) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  assign x         = x_q;
  assign y         = y_q;
  assign chk_en    = chk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault_cnt = fcnt_q;

endmodule

// File: tb/tb_reflect_stim_gen.sv
// Directed bench for reflect_stim_gen: default, no-fault, far-period and every-cycle-fault instances.
module tb_reflect_stim_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fault_en;
  logic [3:0] x_w, y_w, chk_w, busy_w, done_w;
  logic [7:0] fc_w [4];

  int n_assert = 0;
  int n_fail   = 0;

  int          busy_n, chk_n, done_n, done_at, chk_at, xerr, ri;
  int          mism1, mism2, mism3;
  logic [63:0] mask0, xv0, xref;

  always #5 clk = ~clk;

  reflect_stim_gen u0 (
    .clk(clk), .rst(rst), .start(start), .fault_en(fault_en),
    .x(x_w[0]), .y(y_w[0]), .chk_en(chk_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .fault_cnt(fc_w[0])
  );

  reflect_stim_gen #(.FAULT_PERIOD(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .fault_en(fault_en),
    .x(x_w[1]), .y(y_w[1]), .chk_en(chk_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .fault_cnt(fc_w[1])
  );

  reflect_stim_gen #(.FAULT_PERIOD(100)) u2 (
    .clk(clk), .rst(rst), .start(start), .fault_en(fault_en),
    .x(x_w[2]), .y(y_w[2]), .chk_en(chk_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .fault_cnt(fc_w[2])
  );

  reflect_stim_gen #(.FAULT_PERIOD(1)) u3 (
    .clk(clk), .rst(rst), .start(start), .fault_en(fault_en),
    .x(x_w[3]), .y(y_w[3]), .chk_en(chk_w[3]), .busy(busy_w[3]), .done(done_w[3]),
    .fault_cnt(fc_w[3])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent x^8+x^6+x^5+x^4+1 model, right shift, output bit 0
  function automatic logic [7:0] model_step(input logic [7:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[4];
    return {fb, s[7:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch ncyc cycles; pulse start at cycles pa/pb, assert rst at cycle rst_at
  task automatic observe(input int ncyc, input int pa, input int pb, input int rst_at);
    logic [7:0] m;
    m       = 8'hA5;
    busy_n  = 0; chk_n = 0; done_n = 0; done_at = -1; chk_at = -1;
    xerr    = 0; ri = 0; mism1 = 0; mism2 = 0; mism3 = 0;
    mask0   = '0; xv0 = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == rst_at) begin
        check("fault_cnt_before_rst", 64'(fc_w[0]), 64'd1);
        rst = 1'b1;
        #1;
        check("outputs_during_rst",
              64'({x_w[0], y_w[0], chk_w[0], busy_w[0], done_w[0], fc_w[0]}), 64'd0);
        rst = 1'b0;
      end
      if (busy_w[0]) busy_n++;
      if (done_w[0]) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (chk_w[0]) begin
        if (chk_at < 0) chk_at = c;
        chk_n++;
        if (ri < 64) begin
          xv0[ri] = x_w[0];
          if (x_w[0] !== y_w[0]) mask0[ri] = 1'b1;
        end
        ri++;
        if (x_w[0] !== m[0]) xerr++;
        m = model_step(m);
      end
      if (chk_w[1] && (x_w[1] !== y_w[1])) mism1++;
      if (chk_w[2] && (x_w[2] !== y_w[2])) mism2++;
      if (chk_w[3] && (x_w[3] !== y_w[3])) mism3++;
      start = (c == pa) || (c == pb);
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    fault_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x",         64'(x_w[0]),    64'd0);
    check("rst_y",         64'(y_w[0]),    64'd0);
    check("rst_chk_en",    64'(chk_w[0]),  64'd0);
    check("rst_busy",      64'(busy_w[0]), 64'd0);
    check("rst_done",      64'(done_w[0]), 64'd0);
    check("rst_fault_cnt", 64'(fc_w[0]),   64'd0);
    rst = 1'b0;
    tick();

    // Defaults with injection gated off
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_after_start", 64'(busy_w[0]), 64'd1);
    observe(80, -1, -1, -1);
    check("t1_busy_cycles",   64'(busy_n),  64'd66);
    check("t1_chk_cycles",    64'(chk_n),   64'd64);
    check("t1_chk_first",     64'(chk_at),  64'd2);
    check("t1_done_count",    64'(done_n),  64'd1);
    check("t1_done_at",       64'(done_at), 64'd66);
    check("t1_mismatch_mask", mask0,        64'd0);
    check("t1_fault_cnt",     64'(fc_w[0]), 64'd0);
    check("t1_first8_x",      64'(xv0[7:0]), 64'hA5);
    check("t1_x_model_errs",  64'(xerr),    64'd0);
    xref = xv0;

    // Injection on; start pulses while busy and during DONE must be ignored
    fault_en = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    observe(80, 10, 66, -1);
    check("t2_mismatch_mask", mask0,        64'h8000_8000_8000_8000);
    check("t2_fault_cnt",     64'(fc_w[0]), 64'd4);
    check("t2_done_count",    64'(done_n),  64'd1);
    check("t2_busy_cycles",   64'(busy_n),  64'd66);
    check("t2_x_repeat",      xv0,          xref);
    check("t2_fp0_mism",      64'(mism1),   64'd0);
    check("t2_fp0_cnt",       64'(fc_w[1]), 64'd0);
    check("t2_fp100_mism",    64'(mism2),   64'd0);
    check("t2_fp100_cnt",     64'(fc_w[2]), 64'd0);
    check("t2_fp1_mism",      64'(mism3),   64'd64);
    check("t2_fp1_cnt",       64'(fc_w[3]), 64'd64);

    // Reset at run index 20 (cycle 22 after start)
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(40, -1, -1, 22);
    check("t3_no_done",     64'(done_n), 64'd0);
    check("t3_busy_cycles", 64'(busy_n), 64'd22);

    // Fresh sequence after mid-run reset
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(80, -1, -1, -1);
    check("t4_mismatch_mask", mask0,        64'h8000_8000_8000_8000);
    check("t4_fault_cnt",     64'(fc_w[0]), 64'd4);
    check("t4_x_repeat",      xv0,          xref);
    check("t4_x_model_errs",  64'(xerr),    64'd0);
    check("t4_done_count",    64'(done_n),  64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
